// File: rtl/io_stream_pkg.sv
// io_stream_pkg: packer state encoding and width/ratio helpers for io_stream_bridge
package io_stream_pkg;
   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} pack_state_t;
   function automatic int ratio(input int core_w, input int pad_w);
      return core_w / pad_w;
   endfunction
   function automatic bit width_ok(input int core_w, input int pad_w);
      return pad_w > 0 && core_w >= pad_w && core_w % pad_w == 0;
   endfunction
   function automatic bit depth_ok(input int depth);
      return depth >= 2 && (depth & (depth - 1)) == 0;
   endfunction
   function automatic int cnt_w(input int r);
      return r > 1 ? $clog2(r) : 1;
   endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: power-of-two word FIFO with combinational head read and sync active-low reset
module stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wr, rd;
   logic [PW:0] cnt;
   logic wr_en, rd_en;
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign full  = cnt == (PW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign dout  = mem[rd];
   // Storage, wrapping pointers and occupancy; push and pop in one cycle leave cnt unchanged
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr  <= '0;
         rd  <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr] <= din;
            wr      <= wr + 1'b1;
         end
         if (rd_en) rd <= rd + 1'b1;
         cnt <= cnt + (PW+1)'(wr_en) - (PW+1)'(rd_en);
      end
   end
endmodule

// File: rtl/io_stream_bridge.sv
// io_stream_bridge: pad-to-core beat packer and core-to-pad word unpacker; define OUT_FIFO_EN for a FIFO_DEPTH-word output buffer, otherwise a single word is held
module io_stream_bridge
   import io_stream_pkg::*;
#(
   parameter int PAD_IN_W   = 8,
   parameter int CORE_IN_W  = 32,
   parameter int PAD_OUT_W  = 16,
   parameter int CORE_OUT_W = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                           wb_clk_i,
   input  logic                                           wb_rst_ni,
   input  logic                                           pad_in_valid_i,
   input  logic [PAD_IN_W-1:0]                            pad_in_data_i,
   input  logic                                           pad_in_last_i,
   output logic                                           pad_in_ready_o,
   output logic                                           core_in_valid_o,
   output logic [CORE_IN_W-1:0]                           core_in_data_o,
   output logic [ratio(CORE_IN_W, PAD_IN_W)-1:0]          core_in_keep_o,
   output logic                                           core_in_last_o,
   input  logic                                           core_in_ready_i,
   input  logic                                           core_out_valid_i,
   input  logic [CORE_OUT_W-1:0]                          core_out_data_i,
   input  logic                                           core_out_last_i,
   output logic                                           core_out_ready_o,
   output logic                                           pad_out_valid_o,
   output logic [PAD_OUT_W-1:0]                           pad_out_data_o,
   output logic                                           pad_out_last_o,
   input  logic                                           pad_out_ready_i
);
   localparam int IN_R  = ratio(CORE_IN_W, PAD_IN_W);
   localparam int OUT_R = ratio(CORE_OUT_W, PAD_OUT_W);
   localparam int ICW   = cnt_w(IN_R);
   localparam int OCW   = cnt_w(OUT_R);

   if (!width_ok(CORE_IN_W, PAD_IN_W)) begin : g_bad_in
      $error("CORE_IN_W must be a multiple of PAD_IN_W");
   end
   if (!width_ok(CORE_OUT_W, PAD_OUT_W)) begin : g_bad_out
      $error("CORE_OUT_W must be a multiple of PAD_OUT_W");
   end
   if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end

   logic run;
   // Registered copy of reset: keeps both ready outputs low through reset and raises them on the first edge after release
   always_ff @(posedge wb_clk_i) run <= wb_rst_ni;

   pack_state_t state, state_nx;
   logic [ICW-1:0] cnt_in;
   logic [CORE_IN_W-1:0] in_data;
   logic [IN_R-1:0] in_keep;
   logic in_last, beat, word;
   assign pad_in_ready_o  = run & (state == FILL);
   assign core_in_valid_o = state == HOLD;
   assign core_in_data_o  = in_data;
   assign core_in_keep_o  = in_keep;
   assign core_in_last_o  = in_last;
   assign beat = pad_in_valid_i & pad_in_ready_o;
   assign word = core_in_valid_o & core_in_ready_i;
   // Packer state register
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) state <= FILL;
      else state <= state_nx;
   end
   // Packer next state: close the word on its final slot or on a packet end, reopen once the core takes it
   always_comb begin
      state_nx = state;
      state_nx = state == FILL ? (beat && (cnt_in == ICW'(IN_R - 1) || pad_in_last_i) ? HOLD : FILL)
                               : (word ? FILL : HOLD);
   end
   // Packer datapath: write each beat into its slot; clearing after hand-off keeps short packets zero-padded
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni || word) begin
         in_data <= '0;
         in_keep <= '0;
         in_last <= 1'b0;
         cnt_in  <= '0;
      end else if (beat) begin
         in_data[cnt_in*PAD_IN_W +: PAD_IN_W] <= pad_in_data_i;
         in_keep[cnt_in] <= 1'b1;
         in_last <= pad_in_last_i;
         cnt_in  <= cnt_in + 1'b1;
      end
   end

   logic buf_valid, buf_last, buf_full, push, pop;
   logic [CORE_OUT_W-1:0] buf_data;
   assign core_out_ready_o = run & ~buf_full;
   assign push = core_out_valid_i & core_out_ready_o;

`ifdef OUT_FIFO_EN
   logic buf_empty;
   stream_fifo #(.WIDTH(CORE_OUT_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .push  (push),
      .din   ({core_out_last_i, core_out_data_i}),
      .pop   (pop),
      .dout  ({buf_last, buf_data}),
      .full  (buf_full),
      .empty (buf_empty)
   );
   assign buf_valid = ~buf_empty;
`else
   assign buf_full = buf_valid;
   // Single-word holding register: loads only when empty, so a pop is never refilled in the same cycle
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         buf_valid <= 1'b0;
         buf_data  <= '0;
         buf_last  <= 1'b0;
      end else if (push) begin
         buf_valid <= 1'b1;
         buf_data  <= core_out_data_i;
         buf_last  <= core_out_last_i;
      end else if (pop) begin
         buf_valid <= 1'b0;
      end
   end
`endif

   logic [OCW-1:0] cnt_out;
   logic out_end;
   assign out_end         = cnt_out == OCW'(OUT_R - 1);
   assign pad_out_valid_o = buf_valid;
   assign pad_out_data_o  = buf_data[cnt_out*PAD_OUT_W +: PAD_OUT_W];
   assign pad_out_last_o  = buf_valid & buf_last & out_end;
   assign pop = pad_out_valid_o & pad_out_ready_i & out_end;
   // Unpacker slot counter: steps per pad beat, wraps as the head word retires
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) cnt_out <= '0;
      else if (pad_out_valid_o && pad_out_ready_i) cnt_out <= out_end ? '0 : cnt_out + 1'b1;
   end
endmodule
